vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 22, meaning the memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory word width (four 8-bit grey pixels).
REQ-003 The block SHALL have parameter RD_LAT, default 2, meaning the cycles from memory command to valid mem_rdata (range 1..4).
REQ-004 The block SHALL have parameter CPU_MAX_WAIT, default 8, meaning the consecutive CPU denials before a forced CPU slot.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: `clk` (input, 1 bit, rising-edge clock) and `rst_n` (input, 1 bit, asynchronous active-low reset).
REQ-006 The block SHALL have the following VGA-port signals:
- `vga_req`, input, 1 bit: pixel-fetcher read request.
- `vga_addr`, input, ADDR_W bits: read word address.
- `vga_gnt`, output, 1 bit: request accepted this cycle.
- `vga_rvalid`, output, 1 bit: read data valid for the VGA port.
REQ-007 The block SHALL have the following CPU-port signals:
- `cpu_req`, input, 1 bit: CPU access request.
- `cpu_we`, input, 1 bit: 1 = write, 0 = read.
- `cpu_addr`, input, ADDR_W bits: word address.
- `cpu_wdata`, input, DATA_W bits: write data.
- `cpu_gnt`, output, 1 bit: request accepted.
- `cpu_rvalid`, output, 1 bit: read data valid for the CPU port.
REQ-008 The block SHALL have the following memory-side signals:
- `mem_en`, output, 1 bit: command valid.
- `mem_we`, output, 1 bit: write enable.
- `mem_addr`, output, ADDR_W bits.
- `mem_wdata`, output, DATA_W bits.
- `mem_rdata`, input, DATA_W bits.
- `rdata`, output, DATA_W bits: mem_rdata passed through to both ports, qualified by the per-port rvalid.

Function
REQ-009 The arbiter SHALL grant at most one requester per cycle; `vga_gnt` and `cpu_gnt` are combinational from the requests and the registered state, and are never both high.
REQ-010 The arbiter SHALL drive the memory command combinationally in the cycle of the grant:
- mem_en = vga_gnt | cpu_gnt.
- mem_addr = address of the granted port.
- mem_we = cpu_gnt & cpu_we.
- mem_wdata = cpu_wdata.
- With no grant, mem_en = 0, mem_we = 0, and address/data are don't-care.
REQ-011 The FSM SHALL have two states, NORMAL and FORCE_CPU.
- NORMAL: VGA has strict priority; CPU is granted only when vga_req = 0.
- FORCE_CPU: CPU is granted if cpu_req = 1; otherwise VGA may be granted.
REQ-012 A 4-bit saturating wait counter SHALL behave as follows:
- It increments each cycle cpu_req = 1 and cpu_gnt = 0.
- It clears on cpu_gnt or when cpu_req = 0.
- It saturates at CPU_MAX_WAIT.
REQ-013 The FSM SHALL make its transitions as follows:
- NORMAL -> FORCE_CPU when the counter reaches CPU_MAX_WAIT.
- FORCE_CPU -> NORMAL on the cycle after a cpu_gnt, or when cpu_req drops.
- A forced slot lasts exactly one grant.
REQ-014 A response tag pipeline RD_LAT deep SHALL carry {valid, owner} for each read grant; writes enter no tag.
REQ-015 The per-port rvalid SHALL assert exactly RD_LAT cycles after its read grant, for one cycle per grant, with rdata = mem_rdata in that cycle.
REQ-016 Back-to-back grants SHALL be supported every cycle, and responses SHALL return in grant order with no bubbles inserted by the arbiter.
REQ-017 When vga_req and cpu_req are simultaneous in NORMAL with counter < CPU_MAX_WAIT, VGA SHALL win; in FORCE_CPU, CPU SHALL win and vga_gnt = 0.
REQ-018 Requesters SHALL hold req/addr/data stable until granted; a requester that drops req before grant is not granted and SHALL see no error.

Reset
REQ-019 While rst_n = 0, asynchronously, the following SHALL hold:
- The FSM is in NORMAL.
- The wait counter is 0.
- All tag valids are 0.
- vga_rvalid, cpu_rvalid, vga_gnt, cpu_gnt, mem_en and mem_we are 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight reads, with no rvalid issued for them after reset release.
REQ-021 Grants SHALL resume in the first clock edge after rst_n rises.

Configuration
REQ-022 The macro VGA_ARB_STARVE_GUARD_EN SHALL select the starvation guard.
- Defined: the wait counter and the FORCE_CPU behaviour of REQ-011..013 are compiled in.
- Undefined: the counter and FORCE_CPU are absent; the FSM stays in NORMAL; strict VGA priority applies; a CPU stalled indefinitely is permitted.

Structure
REQ-023 The package vga_mem_pkg SHALL hold the following:
- The arb_state_t enum (NORMAL, FORCE_CPU).
- The owner_t enum (OWN_VGA, OWN_CPU).
- The rsp_tag_t struct {valid, owner}.
- Constants for the default ADDR_W and DATA_W.
REQ-024 The tag pipeline SHALL be the sub-module vga_arb_rsp_pipe (parameter RD_LAT; inputs push and owner; outputs vga_rvalid and cpu_rvalid); all other logic is in the top module.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- VGA-only read stream: vga_req = 1 for 10 cycles at addresses 0..9 -> vga_gnt high on all 10; vga_rvalid high cycles 2..11 (RD_LAT = 2); rdata follows memory contents for 0..9.
- Simultaneous requests: vga_req and cpu_req both high, CPU read at 22501 -> VGA granted; cpu_gnt = 0 until vga_req drops; cpu_rvalid 2 cycles after its grant.
- Starvation, guard enabled: vga_req held high, cpu_req high -> cpu_gnt exactly once, on the 9th cycle, with vga_gnt = 0 that cycle; VGA granted again the next cycle.
- Starvation, guard disabled: same stimulus for 50 cycles -> cpu_gnt never asserts.
- CPU write: cpu_we = 1, address 0x0000A, data 0xDEADBEEF -> mem_en = mem_we = 1 with that address and data; no cpu_rvalid; a following read of 0x0000A returns 0xDEADBEEF.
- Reset mid-flight: rst_n low one cycle after a VGA read grant -> vga_rvalid never asserts for that read; all outputs are 0 during reset.

Source files
------------

// File: rtl/vga_mem_pkg.sv
// ---------------------------------------------------------------------------
// vga_mem_pkg
// Shared types and defaults for the VGA / CPU memory arbiter slice.
//   arb_state_t : arbiter FSM states (NORMAL, FORCE_CPU)
//   owner_t     : which port a returning read belongs to
//   rsp_tag_t   : one slot of the read-response tag pipeline {valid, owner}
//   DEF_ADDR_W / DEF_DATA_W : default memory word-address and word widths
// ---------------------------------------------------------------------------
package vga_mem_pkg;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_CPU = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rsp_tag_t;

endpackage

// File: rtl/vga_arb_rsp_pipe.sv
// ---------------------------------------------------------------------------
// vga_arb_rsp_pipe
// Delay line of response tags that mirrors the memory read latency. Every
// read grant pushes {valid, owner}; the tag emerges RD_LAT cycles later and
// steers the returning mem_rdata to the right port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears all tags)
//   push        : a read was granted this cycle
//   owner       : 1 = CPU read, 0 = VGA read (only meaningful with push)
//   vga_rvalid  : read data on rdata belongs to the VGA port
//   cpu_rvalid  : read data on rdata belongs to the CPU port
// ---------------------------------------------------------------------------
module vga_arb_rsp_pipe
  import vga_mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic owner,
  output logic vga_rvalid,
  output logic cpu_rvalid
);

  rsp_tag_t [RD_LAT-1:0] tag_q;
  rsp_tag_t [RD_LAT-1:0] tag_d;

  // Stage 0 captures the grant; each later stage copies its predecessor.
  // Empty slots carry a fixed owner so the pipe contents are deterministic.
  always_comb begin
    tag_d          = '0;
    tag_d[0].valid = push;
    tag_d[0].owner = push ? owner_t'(owner) : OWN_VGA;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Asynchronous clear drops every in-flight read, so nothing is reported
  // for commands issued before a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    vga_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].owner == OWN_VGA);
    cpu_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].owner == OWN_CPU);
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
// Two-port arbiter in front of a single-ported pipelined memory. The VGA
// pixel fetcher has priority; the CPU gets the leftover cycles. Grants and
// the memory command are combinational in the request cycle, read data
// returns RD_LAT cycles later on rdata, qualified by vga_rvalid/cpu_rvalid.
//
// Optional feature (macro VGA_ARB_STARVE_GUARD_EN):
//   defined   : a 4-bit saturating wait counter tracks consecutive CPU
//               denials; after CPU_MAX_WAIT of them the FSM enters
//               FORCE_CPU and the CPU wins exactly one grant.
//   undefined : strict VGA priority, the CPU may stall indefinitely.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   vga_req, vga_addr                : pixel-fetch read request
//   vga_gnt, vga_rvalid              : VGA accepted / VGA read data valid
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                        : CPU read/write request
//   cpu_gnt, cpu_rvalid              : CPU accepted / CPU read data valid
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             : memory command and read data
//   rdata                            : mem_rdata passed to both ports
// ---------------------------------------------------------------------------
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 2,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic rd_push;
  logic rd_owner;

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  arb_state_t state_q;
  arb_state_t state_d;
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grants depend on the registered state only, so the forced slot is
  // decided before the cycle starts. Grants are held low while rst_n is low
  // because they are combinational from the requests.
  // The switch to FORCE_CPU looks at the next counter value: the CPU loses
  // CPU_MAX_WAIT cycles and wins the following one.
  always_comb begin
    vga_gnt    = 1'b0;
    cpu_gnt    = 1'b0;
    wait_cnt_d = '0;
    state_d    = state_q;

    if (rst_n) begin
      if (state_q == FORCE_CPU) begin
        cpu_gnt = cpu_req;
        vga_gnt = vga_req & ~cpu_req;
      end else begin
        vga_gnt = vga_req;
        cpu_gnt = cpu_req & ~vga_req;
      end
    end

    if (cpu_req && !cpu_gnt) begin
      wait_cnt_d = (wait_cnt_q >= MAX_WAIT) ? MAX_WAIT : wait_cnt_q + 4'd1;
    end

    unique case (state_q)
      NORMAL: begin
        if (wait_cnt_d == MAX_WAIT) begin
          state_d = FORCE_CPU;
        end
      end
      FORCE_CPU: begin
        if (cpu_gnt || !cpu_req) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end
`else
  // Starvation limit is meaningless without the guard.
  logic unused_max_wait;
  assign unused_max_wait = ^4'(CPU_MAX_WAIT);

  always_comb begin
    vga_gnt = rst_n & vga_req;
    cpu_gnt = rst_n & cpu_req & ~vga_req;
  end
`endif

  // Memory command follows whichever port won this cycle.
  always_comb begin
    mem_en    = vga_gnt | cpu_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_addr  = cpu_gnt ? cpu_addr : vga_addr;
    mem_wdata = cpu_wdata;
  end

  // Only reads produce a response; writes leave no tag.
  always_comb begin
    rd_push  = vga_gnt | (cpu_gnt & ~cpu_we);
    rd_owner = cpu_gnt;
  end

  assign rdata = mem_rdata;

  vga_arb_rsp_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_push),
    .owner     (rd_owner),
    .vga_rvalid(vga_rvalid),
    .cpu_rvalid(cpu_rvalid)
  );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Directed bench for vga_mem_arbiter with a latency-RD_LAT memory model.
// Read grants push the expected {port, data, due cycle} into a queue; a
// monitor pops and compares whenever an rvalid appears.
// ---------------------------------------------------------------------------
module tb_vga_mem_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          is_cpu;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  // Memory model storage: unwritten words return a fixed address pattern.
  bit [31:0] mem     [1024];
  bit        wr_flag [1024];
  bit [31:0] rd_pipe [RD_LAT];

  vga_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RD_LAT      (RD_LAT),
    .CPU_MAX_WAIT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_gnt   (vga_gnt),
    .vga_rvalid(vga_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to time responses.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [21:0] a);
    return 32'h5A00_0000 | {10'd0, a};
  endfunction

  // Memory model: writes land at the clock edge, reads return RD_LAT
  // cycles after the command.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[9:0]]     <= mem_wdata;
      wr_flag[mem_addr[9:0]] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      rd_pipe[0] <= wr_flag[mem_addr[9:0]] ? mem[mem_addr[9:0]] : pat(mem_addr);
    end else begin
      rd_pipe[0] <= 32'd0;
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic vreq, input logic [21:0] vaddr,
                               input logic creq, input logic cwe,
                               input logic [21:0] caddr, input logic [31:0] cwdata);
    vga_req   = vreq;
    vga_addr  = vaddr;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
  endtask

  // One clock cycle: drive, check grants and memory command at the
  // falling edge, queue the expected read response, advance past the edge.
  task automatic run_cycle(input int vreq, input int vaddr, input int creq,
                           input int cwe, input int caddr, input logic [31:0] cwdata,
                           input int exp_vg, input int exp_cg,
                           input logic [31:0] exp_data, input int push,
                           input string tag);
    logic ev;
    logic ec;
    logic ew;
    ev = (exp_vg != 0);
    ec = (exp_cg != 0);
    ew = (cwe != 0);
    applyStimulus(1'(vreq), 22'(vaddr), 1'(creq), 1'(cwe), 22'(caddr), cwdata);
    @(negedge clk);
    checkOutput({tag, " vga_gnt"}, 32'(vga_gnt), 32'(ev));
    checkOutput({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(ec));
    checkOutput({tag, " mem_en"},  32'(mem_en),  32'(ev | ec));
    checkOutput({tag, " mem_we"},  32'(mem_we),  32'(ec & ew));
    if (ev || ec) begin
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), ec ? 32'(caddr) : 32'(vaddr));
    end
    if (ec && ew) begin
      checkOutput({tag, " mem_wdata"}, mem_wdata, cwdata);
    end
    if (push != 0) begin
      if (ev) sb_q.push_back('{1'b0, exp_data, cyc + RD_LAT});
      if (ec && !ew) sb_q.push_back('{1'b1, exp_data, cyc + RD_LAT});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle(0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, "idle");
    end
  endtask

  // Response monitor: every rvalid must match the oldest queued read.
  always @(negedge clk) begin
    if (vga_rvalid || cpu_rvalid) begin
      if (sb_q.size() == 0) begin
        checkOutput("rsp_unexpected", {30'd0, vga_rvalid, cpu_rvalid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("rsp_port", {30'd0, vga_rvalid, cpu_rvalid},
                    mon_e.is_cpu ? 32'd1 : 32'd2);
        checkOutput("rsp_rdata", rdata, mon_e.data);
        checkOutput("rsp_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    #100000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset with both requests asserted: everything must stay quiet.
    rst_n = 1'b0;
    applyStimulus(1'b1, 22'd3, 1'b1, 1'b1, 22'd7, 32'h1111_2222);
    #12;
    checkOutput("reset vga_gnt",    32'(vga_gnt),    32'd0);
    checkOutput("reset cpu_gnt",    32'(cpu_gnt),    32'd0);
    checkOutput("reset mem_en",     32'(mem_en),     32'd0);
    checkOutput("reset mem_we",     32'(mem_we),     32'd0);
    checkOutput("reset vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // VGA-only stream, addresses 0..9, granted every cycle.
    for (int i = 0; i < 10; i++) begin
      run_cycle(1, i, 0, 0, 0, 32'd0, 1, 0, pat(22'(i)), 1, "vga_stream");
    end
    idle(3);

    // Simultaneous requests: VGA wins until it drops, then CPU read 22501.
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 20 + i, 1, 0, 22501, 32'd0, 1, 0, pat(22'(20 + i)), 1, "simul_vga");
    end
    run_cycle(0, 0, 1, 0, 22501, 32'd0, 0, 1, 32'h5A00_57E5, 1, "simul_cpu");
    idle(3);

    // CPU write then read-back of the same word.
    run_cycle(0, 0, 1, 1, 'hA, 32'hDEAD_BEEF, 0, 1, 32'd0, 0, "cpu_write");
    idle(1);
    run_cycle(0, 0, 1, 0, 'hA, 32'd0, 0, 1, 32'hDEAD_BEEF, 1, "cpu_readback");
    idle(3);

`ifdef VGA_ARB_STARVE_GUARD_EN
    // Guard on: eight denials, then one forced CPU slot, then VGA again.
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, 100 + i, 1, 0, 21, 32'd0, 1, 0, pat(22'(100 + i)), 1, "starve_wait");
    end
    run_cycle(1, 108, 1, 0, 21, 32'd0, 0, 1, 32'h5A00_0015, 1, "starve_force");
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 108 + i, 0, 0, 0, 32'd0, 1, 0, pat(22'(108 + i)), 1, "starve_after");
    end
`else
    // Guard off: the CPU never gets in while VGA keeps requesting.
    for (int i = 0; i < 50; i++) begin
      run_cycle(1, 100 + i, 1, 0, 21, 32'd0, 1, 0, pat(22'(100 + i)), 1, "starve_noguard");
    end
`endif
    idle(3);

    // Reset one cycle after a VGA read grant: that read must never return.
    run_cycle(1, 5, 0, 0, 0, 32'd0, 1, 0, 32'd0, 0, "rst_flight_gnt");
    rst_n = 1'b0;
    applyStimulus(1'b1, 22'd6, 1'b1, 1'b1, 22'd8, 32'h1234_5678);
    #2;
    checkOutput("rst_flight vga_gnt",    32'(vga_gnt),    32'd0);
    checkOutput("rst_flight cpu_gnt",    32'(cpu_gnt),    32'd0);
    checkOutput("rst_flight mem_en",     32'(mem_en),     32'd0);
    checkOutput("rst_flight mem_we",     32'(mem_we),     32'd0);
    checkOutput("rst_flight vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("rst_flight cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Grants resume straight after reset release.
    run_cycle(1, 7, 0, 0, 0, 32'd0, 1, 0, 32'h5A00_0007, 1, "post_reset");
    idle(4);

    checkOutput("rsp_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
